// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_BUSY,
        S_DIV_BUSY,
        S_DONE
    } mdu_state_e;

    localparam int          MDU_DIV_ITERS = 32;
    localparam int          CNT_W         = 6;
    localparam logic [31:0] DIV0_LO       = 32'hFFFF_FFFF;

    // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring radix-2 divider: one quotient bit per step.
// quo_o/rem_o show the value the current step produces, so the parent can capture on the last step.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        clear_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic [63:0] acc_q;      // {partial remainder, dividend/quotient bits}
    logic [31:0] divisor_q;
    logic [32:0] diff;
    logic [63:0] acc_step;

    always_comb begin
        diff = acc_q[63:31] - {1'b0, divisor_q};
        if (!diff[32]) begin
            acc_step = {diff[31:0], acc_q[30:0], 1'b1};
        end else begin
            acc_step = {acc_q[62:0], 1'b0};
        end
    end

    assign quo_o = acc_step[31:0];
    assign rem_o = acc_step[63:32];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_q     <= '0;
            divisor_q <= '0;
        end else if (clear_i) begin
            acc_q     <= '0;
            divisor_q <= '0;
        end else if (start_i) begin
            acc_q     <= {32'd0, dividend_i};
            divisor_q <= divisor_i;
        end else if (step_i) begin
            acc_q     <= acc_step;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer: drives the external multiplier IP, runs the
// iterative divider, stalls EX while busy and holds HI/LO until the pipeline advances.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic [63:0] mul_p_i,
    output logic        mul_ce_o,
    output logic        mul_sclr_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_by_zero_o
);

    mdu_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic done_q, done_d, dbz_q, dbz_d;
    logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    mdu_op_e op;
    logic is_mul, is_signed, sign_a, sign_b, div_zero;
    logic busy, mul_ce, div_start, div_step;
    logic [31:0] div_quo, div_rem;

    assign op        = mdu_op_e'(op_i);
    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign sign_a    = is_signed & opa_i[31];
    assign sign_b    = is_signed & opb_i[31];
    assign div_zero  = !is_mul && (opb_i == 32'd0);

    mdu_div_core u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (div_start),
        .clear_i    (flush_i),
        .step_i     (div_step),
        .dividend_i (cond_neg(opa_i, sign_a)),
        .divisor_i  (cond_neg(opb_i, sign_b)),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    // NOTE: every variable gets a default before the case so no latches are inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = done_q;
        dbz_d     = dbz_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        busy      = 1'b0;
        mul_ce    = 1'b0;
        div_start = 1'b0;
        div_step  = 1'b0;

        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        busy = 1'b1;
                        if (div_zero) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            dbz_d   = 1'b1;
                            lo_d    = DIV0_LO;
                            hi_d    = opa_i;
                        end else if (is_mul) begin
                            mul_ce  = 1'b1;
                            state_d = S_MUL_BUSY;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            div_start = 1'b1;
                            neg_quo_d = sign_a ^ sign_b;
                            neg_rem_d = sign_a;
                            state_d   = S_DIV_BUSY;
                            cnt_d     = CNT_W'(1);
                        end
                    end
                end
                S_MUL_BUSY: begin
                    busy   = 1'b1;
                    mul_ce = (cnt_q < CNT_W'(MUL_LAT));
                    if (cnt_q == CNT_W'(MUL_LAT)) begin
                        {hi_d, lo_d} = mul_p_i;
                        done_d  = 1'b1;
                        dbz_d   = 1'b0;
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DIV_BUSY: begin
                    busy     = 1'b1;
                    div_step = 1'b1;
                    if (cnt_q == CNT_W'(MDU_DIV_ITERS)) begin
                        lo_d    = cond_neg(div_quo, neg_quo_q);
                        hi_d    = cond_neg(div_rem, neg_rem_q);
                        done_d  = 1'b1;
                        dbz_d   = 1'b0;
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // start_i still belongs to the completed op here, so it is ignored.
                    if (!hold_i) begin
                        state_d = S_IDLE;
                        done_d  = 1'b0;
                        dbz_d   = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign busy_o        = rst_i & busy;
    assign mul_ce_o      = rst_i & mul_ce;
    assign mul_sclr_o    = rst_i & flush_i;
    assign done_o        = done_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus randomized ops
// compared against an arithmetic reference model and a behavioural multiplier IP.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MUL_LAT = 6;
    localparam int DIV_LAT = 33;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, flush_i, hold_i;
    logic [1:0]  op_i;
    logic [31:0] opa_i, opb_i;
    logic [63:0] mul_p_i;
    logic        mul_ce_o, mul_sclr_o, busy_o, done_o, div_by_zero_o;
    logic [31:0] hi_o, lo_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .op_i          (op_i),
        .opa_i         (opa_i),
        .opb_i         (opb_i),
        .flush_i       (flush_i),
        .hold_i        (hold_i),
        .mul_p_i       (mul_p_i),
        .mul_ce_o      (mul_ce_o),
        .mul_sclr_o    (mul_sclr_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Full-precision product of two 32-bit operands, signed or unsigned.
    function automatic logic [63:0] full_product(input logic [1:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa, sb;
        if (op[0] == 1'b0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Multiplier IP: MUL_LAT enabled stages, synchronous clear.
    logic [63:0] mip [MUL_LAT];
    always @(posedge clk_i) begin
        if (mul_sclr_o) begin
            for (int i = 0; i < MUL_LAT; i++) mip[i] <= 64'd0;
        end else if (mul_ce_o) begin
            mip[0] <= full_product(op_i, opa_i, opb_i);
            for (int i = 1; i < MUL_LAT; i++) mip[i] <= mip[i-1];
        end
    end
    assign mul_p_i = mip[MUL_LAT-1];

    task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint sa, sb, q, r;
        logic [63:0] p;
        dbz = 1'b0;
        if (op[1] == 1'b0) begin
            p  = full_product(op, a, b);
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            dbz = 1'b1;
            hi  = a;
            lo  = 32'hFFFF_FFFF;
        end else begin
            if (op[0] == 1'b0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycle();
        tick();
        start_i = 1'b0;
        flush_i = 1'b0;
        hold_i  = 1'b0;
        @(negedge clk_i);
        check("idle_busy", 64'(busy_o), 64'd0);
        check("idle_done", 64'(done_o), 64'd0);
        check("idle_ce",   64'(mul_ce_o), 64'd0);
        check("idle_hi",   64'(hi_o), 64'(last_hi));
        check("idle_lo",   64'(lo_o), 64'(last_lo));
    endtask

    // Cycles 0..n-1 of an op: stall asserted, multiplier enabled only for its first MUL_LAT cycles.
    task automatic busy_cycles(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            if (c == 0) begin
                start_i = 1'b1;
                flush_i = 1'b0;
                hold_i  = 1'b0;
                op_i    = op;
                opa_i   = a;
                opb_i   = b;
            end else if (op[1]) begin
                opa_i = $urandom;
                opb_i = $urandom;
            end
            @(negedge clk_i);
            check($sformatf("busy_c%0d", c), 64'(busy_o), 64'd1);
            check($sformatf("ce_c%0d", c), 64'(mul_ce_o), 64'(!op[1] && c < MUL_LAT));
            check($sformatf("done_c%0d", c), 64'(done_o), 64'd0);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int nhold);
        logic [31:0] eh, el;
        logic        edbz;
        int          lat;
        ref_model(op, a, b, eh, el, edbz);
        lat = !op[1] ? MUL_LAT + 1 : (b == 32'd0 ? 1 : DIV_LAT);
        busy_cycles(op, a, b, lat);
        for (int d = 0; d <= nhold; d++) begin
            tick();
            hold_i = (d < nhold);
            @(negedge clk_i);
            check("done",     64'(done_o), 64'd1);
            check("done_busy", 64'(busy_o), 64'd0);
            check("done_ce",  64'(mul_ce_o), 64'd0);
            check("hi",       64'(hi_o), 64'(eh));
            check("lo",       64'(lo_o), 64'(el));
            check("dbz",      64'(div_by_zero_o), 64'(edbz));
        end
        last_hi = eh;
        last_lo = el;
    endtask

    task automatic flush_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int at);
        busy_cycles(op, a, b, at);
        tick();
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_sclr", 64'(mul_sclr_o), 64'd1);
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_ce",   64'(mul_ce_o), 64'd0);
        check("flush_done", 64'(done_o), 64'd0);
        idle_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          sel;

        rst_i   = 1'b0;
        start_i = 1'b0;
        flush_i = 1'b0;
        hold_i  = 1'b0;
        op_i    = 2'b00;
        opa_i   = 32'd0;
        opb_i   = 32'd0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_dbz",  64'(div_by_zero_o), 64'd0);
        tick();
        rst_i = 1'b1;
        idle_cycle();

        run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0);
        run_op(OP_DIVU,  32'd100, 32'd7, 0);
        run_op(OP_DIVU,  32'd7, 32'd0, 0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1);
        idle_cycle();

        flush_op(OP_DIV, 32'd1234, 32'd5, 10);
        run_op(OP_MULTU, 32'd5, 32'd6, 0);
        flush_op(OP_MULT, 32'd77, 32'd11, 3);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0);

        // Flush coinciding with start in IDLE: op must not be accepted.
        tick();
        start_i = 1'b1;
        op_i    = OP_MULTU;
        flush_i = 1'b1;
        @(negedge clk_i);
        check("fs_busy", 64'(busy_o), 64'd0);
        check("fs_ce",   64'(mul_ce_o), 64'd0);
        check("fs_sclr", 64'(mul_sclr_o), 64'd1);
        idle_cycle();
        idle_cycle();

        run_op(OP_DIVU, 32'd1000, 32'd33, 3);
        idle_cycle();

        // Reset in cycle 15 of a divide clears all outputs at once.
        busy_cycles(OP_DIV, 32'hDEAD_BEEF, 32'd3, 15);
        tick();
        rst_i = 1'b0;
        #1;
        check("mrst_busy", 64'(busy_o), 64'd0);
        check("mrst_done", 64'(done_o), 64'd0);
        check("mrst_hilo", {hi_o, lo_o}, 64'd0);
        check("mrst_ce",   64'(mul_ce_o), 64'd0);
        check("mrst_sclr", 64'(mul_sclr_o), 64'd0);
        check("mrst_dbz",  64'(div_by_zero_o), 64'd0);
        start_i = 1'b0;
        last_hi = 32'd0;
        last_lo = 32'd0;
        tick();
        rst_i = 1'b1;
        idle_cycle();

        for (int it = 0; it < 24; it++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else               rb = $urandom;
            if ($urandom_range(0, 5) == 0 && !(rop[1] && rb == 32'd0)) begin
                flush_op(rop, ra, rb, $urandom_range(1, rop[1] ? DIV_LAT - 1 : MUL_LAT));
            end else begin
                run_op(rop, ra, rb, $urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
